// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS controller:
// opcodes, state codes, select encodings and the decode bundle.
package mc_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    localparam logic [2:0] NPC_SEQ = 3'd0;
    localparam logic [2:0] NPC_BR  = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_LUI  = 2'd1;
    localparam logic [1:0] EXT_SIGN = 2'd2;
    localparam logic [1:0] EXT_BR   = 2'd3;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_XOR  = 3'd3;
    localparam logic [2:0] ALU_SRLV = 3'd4;
    localparam logic [2:0] ALU_LUI  = 3'd5;
    localparam logic [2:0] ALU_GTZ  = 3'd6;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_JR,
        CLS_JAL
    } instrClass_t;

    typedef struct packed {
        logic        legal;
        instrClass_t cls;
        logic        aluSrc;
        logic        dmSel;
        logic [1:0]  regDst;
        logic [1:0]  mem2reg;
        logic [1:0]  extOp;
        logic [2:0]  aluCode;
    } decode_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational op/funct decoder: instruction class,
// static datapath selects and legality.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output decode_t    dec
);

    logic isR;

    assign isR = (op == OP_RTYPE);

    always_comb begin
        dec.legal   = 1'b1;
        dec.cls     = CLS_ALU;
        dec.aluSrc  = 1'b0;
        dec.dmSel   = 1'b0;
        dec.regDst  = RD_RT;
        dec.mem2reg = M2R_ALU;
        dec.extOp   = EXT_ZERO;
        dec.aluCode = ALU_ADD;
        unique case (1'b1)
            isR && (funct == FN_ADDU): dec.regDst = RD_RD;
            isR && (funct == FN_SUBU): begin
                dec.regDst  = RD_RD;
                dec.aluCode = ALU_SUB;
            end
            isR && (funct == FN_SRLV): begin
                dec.regDst  = RD_RD;
                dec.aluCode = ALU_SRLV;
            end
            isR && (funct == FN_JR): dec.cls = CLS_JR;
            op == OP_ORI: begin
                dec.aluSrc  = 1'b1;
                dec.aluCode = ALU_OR;
            end
            op == OP_XORI: begin
                dec.aluSrc  = 1'b1;
                dec.aluCode = ALU_XOR;
            end
            op == OP_LUI: begin
                dec.aluSrc  = 1'b1;
                dec.extOp   = EXT_LUI;
                dec.aluCode = ALU_LUI;
            end
            op == OP_LW: begin
                dec.cls     = CLS_LOAD;
                dec.aluSrc  = 1'b1;
                dec.extOp   = EXT_SIGN;
                dec.mem2reg = M2R_MDR;
            end
            op == OP_LH: begin
                dec.cls     = CLS_LOAD;
                dec.aluSrc  = 1'b1;
                dec.extOp   = EXT_SIGN;
                dec.mem2reg = M2R_MDR;
                dec.dmSel   = 1'b1;
            end
            op == OP_SW: begin
                dec.cls    = CLS_STORE;
                dec.aluSrc = 1'b1;
                dec.extOp  = EXT_SIGN;
            end
            op == OP_BEQ: begin
                dec.cls     = CLS_BRANCH;
                dec.extOp   = EXT_BR;
                dec.aluCode = ALU_SUB;
            end
            op == OP_BGTZ: begin
                dec.cls     = CLS_BRANCH;
                dec.extOp   = EXT_BR;
                dec.aluCode = ALU_GTZ;
            end
            op == OP_J: dec.cls = CLS_JUMP;
            op == OP_JAL: begin
                dec.cls     = CLS_JAL;
                dec.regDst  = RD_RA;
                dec.mem2reg = M2R_PC4;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM with memory wait timeout,
// illegal-opcode trap and retired-instruction counter.
module mc_controller
    import mc_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               br_cond,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_req,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               reg_write,
    output logic               alu_src,
    output logic               dm_sel,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem2reg,
    output logic [1:0]         ext_op,
    output logic [2:0]         npc_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done,
    output logic               illegal,
    output logic               bus_err,
    output logic [CNT_W-1:0]   retired,
    output logic [2:0]         state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;

    decode_t           dec;
    logic [2:0]        cur;
    logic [2:0]        nxt;
    logic [WAIT_W-1:0] waitCnt;
    logic              waiting;
    logic              timedOut;
    logic              selActive;

    mc_ctrl_decode uDecode (
        .op    (op),
        .funct (funct),
        .dec   (dec)
    );

    assign state     = cur;
    assign waiting   = ((cur == FETCH) || (cur == MEM)) && !mem_ready;
    // The limit is hit on the last allowed wait cycle; a ready in that cycle is not a wait.
    assign timedOut  = waiting && (MEM_TIMEOUT != 0)
                     && (waitCnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign selActive = cur inside {DECODE, EXEC, MEM, WB};
    assign illegal   = (cur == DECODE) && !dec.legal;

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:   nxt = FETCH;
            FETCH: begin
                if (mem_ready)     nxt = DECODE;
                else if (timedOut) nxt = HALT;
            end
            DECODE: nxt = dec.legal ? EXEC : FETCH;
            EXEC: begin
                unique case (dec.cls)
                    CLS_ALU:             nxt = WB;
                    CLS_LOAD, CLS_STORE: nxt = MEM;
                    default:             nxt = FETCH;
                endcase
            end
            MEM: begin
                if (mem_ready)     nxt = (dec.cls == CLS_STORE) ? FETCH : WB;
                else if (timedOut) nxt = HALT;
            end
            WB:     nxt = FETCH;
            HALT:   nxt = HALT;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        npc_sel    = NPC_SEQ;
        instr_done = 1'b0;
        alu_src    = selActive ? dec.aluSrc : 1'b0;
        dm_sel     = selActive ? dec.dmSel : 1'b0;
        reg_dst    = selActive ? dec.regDst : RD_RT;
        mem2reg    = selActive ? dec.mem2reg : M2R_ALU;
        ext_op     = selActive ? dec.extOp : EXT_ZERO;
        alu_op     = selActive ? ALUOP_W'(dec.aluCode) : ALUOP_W'(ALU_ADD);
        unique case (cur)
            FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            EXEC: begin
                unique case (dec.cls)
                    CLS_BRANCH: begin
                        pc_write   = br_cond;
                        npc_sel    = NPC_BR;
                        instr_done = 1'b1;
                    end
                    CLS_JUMP: begin
                        pc_write   = 1'b1;
                        npc_sel    = NPC_J;
                        instr_done = 1'b1;
                    end
                    CLS_JR: begin
                        pc_write   = 1'b1;
                        npc_sel    = NPC_JR;
                        instr_done = 1'b1;
                    end
                    CLS_JAL: begin
                        pc_write   = 1'b1;
                        npc_sel    = NPC_J;
                        reg_write  = 1'b1;
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                mem_req    = 1'b1;
                i_or_d     = 1'b1;
                mem_write  = (dec.cls == CLS_STORE);
                instr_done = mem_ready && (dec.cls == CLS_STORE);
            end
            WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= IDLE;
            waitCnt <= '0;
            bus_err <= 1'b0;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (nxt != cur)   waitCnt <= '0;
            else if (waiting) waitCnt <= waitCnt + WAIT_W'(1);
            if (timedOut)     bus_err <= 1'b1;
            if (instr_done)   retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller against
// an instruction-level reference model.
`timescale 1ns/1ps
module tb_mc_controller;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BR    = 3;
    localparam int K_J     = 4;
    localparam int K_JR    = 5;
    localparam int K_JAL   = 6;
    localparam int K_BAD   = 7;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         kind;
        logic [1:0] regDst;
        logic [1:0] mem2reg;
        logic [1:0] extOp;
        logic       aluSrc;
        logic       dmSel;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  op = '0;
    logic [5:0]  funct = '0;
    logic        br_cond = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, mem_req, mem_write, i_or_d;
    logic        reg_write, alu_src, dm_sel;
    logic [1:0]  reg_dst, mem2reg, ext_op;
    logic [2:0]  npc_sel;
    logic [2:0]  alu_op;
    logic        instr_done, illegal, bus_err;
    logic [31:0] retired;
    logic [2:0]  state;

    int nChecks = 0;
    int nFails  = 0;
    int modelRetired = 0;
    instr_t tbl[17];

    always #5 clk = ~clk;

    mc_controller #(
        .ALUOP_W(3), .MEM_TIMEOUT(16), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
        .br_cond(br_cond), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req),
        .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
        .alu_src(alu_src), .dm_sel(dm_sel), .reg_dst(reg_dst),
        .mem2reg(mem2reg), .ext_op(ext_op), .npc_sel(npc_sel),
        .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal),
        .bus_err(bus_err), .retired(retired), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic [5:0] o, input logic [5:0] f,
                                  input int k, input logic [1:0] rd,
                                  input logic [1:0] m2r, input logic [1:0] ext,
                                  input logic src, input logic dm);
        instr_t r;
        r.op = o; r.funct = f; r.kind = k; r.regDst = rd;
        r.mem2reg = m2r; r.extOp = ext; r.aluSrc = src; r.dmSel = dm;
        return r;
    endfunction

    task automatic strobes(input string t, input logic pcW, input logic irW,
                           input logic req, input logic wr, input logic iod,
                           input logic regW, input logic done, input logic ill);
        check({t, ".pc_write"}, 32'(pc_write), 32'(pcW));
        check({t, ".ir_write"}, 32'(ir_write), 32'(irW));
        check({t, ".mem_req"}, 32'(mem_req), 32'(req));
        check({t, ".mem_write"}, 32'(mem_write), 32'(wr));
        check({t, ".i_or_d"}, 32'(i_or_d), 32'(iod));
        check({t, ".reg_write"}, 32'(reg_write), 32'(regW));
        check({t, ".instr_done"}, 32'(instr_done), 32'(done));
        check({t, ".illegal"}, 32'(illegal), 32'(ill));
    endtask

    task automatic allZero(input string t);
        strobes(t, 0, 0, 0, 0, 0, 0, 0, 0);
        check({t, ".selects"},
              32'({alu_src, dm_sel, reg_dst, mem2reg, ext_op, npc_sel}), 0);
        check({t, ".alu_op"}, 32'(alu_op), 0);
        check({t, ".bus_err"}, 32'(bus_err), 0);
        check({t, ".retired"}, retired, 0);
        check({t, ".state"}, 32'(state), 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0; mem_ready = 1'b0; op = '0; funct = '0; br_cond = 1'b0;
        #1;
        allZero("reset");
        repeat (2) @(posedge clk);
        #1;
        allZero("reset.held");
        modelRetired = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic runInstr(input instr_t ins, input int fDly,
                            input int mDly, input logic brc);
        bit needMem;
        bit needWb;
        needMem = (ins.kind == K_LOAD) || (ins.kind == K_STORE);
        needWb  = (ins.kind == K_LOAD) || (ins.kind == K_ALU);
        for (int k = 0; k <= fDly; k++) begin
            op = ins.op; funct = ins.funct; br_cond = 1'($urandom);
            mem_ready = (k == fDly);
            #1;
            check("fetch.state", 32'(state), 1);
            strobes("fetch", mem_ready, mem_ready, 1, 0, 0, 0, 0, 0);
            check("fetch.alu_op", 32'(alu_op), 0);
            check("fetch.npc_sel", 32'(npc_sel), 0);
            check("fetch.sel", 32'({alu_src, reg_dst, mem2reg, ext_op}), 0);
            nextCycle();
        end
        mem_ready = 1'($urandom); br_cond = brc;
        #1;
        check("decode.state", 32'(state), 2);
        strobes("decode", 0, 0, 0, 0, 0, 0, 0, ins.kind == K_BAD);
        nextCycle();
        if (ins.kind == K_BAD) begin
            check("illegal.retired", retired, 32'(modelRetired));
            return;
        end
        mem_ready = 1'($urandom);
        #1;
        check("exec.state", 32'(state), 3);
        unique case (ins.kind)
            K_BR: begin
                strobes("exec.br", brc, 0, 0, 0, 0, 0, 1, 0);
                check("exec.br.npc", 32'(npc_sel), 1);
                check("exec.br.ext", 32'(ext_op), 32'(ins.extOp));
            end
            K_J, K_JR: begin
                strobes("exec.j", 1, 0, 0, 0, 0, 0, 1, 0);
                check("exec.j.npc", 32'(npc_sel), (ins.kind == K_J) ? 2 : 3);
            end
            K_JAL: begin
                strobes("exec.jal", 1, 0, 0, 0, 0, 1, 1, 0);
                check("exec.jal.npc", 32'(npc_sel), 2);
                check("exec.jal.dst", 32'({reg_dst, mem2reg}), 32'({2'd2, 2'd2}));
            end
            default: begin
                strobes("exec", 0, 0, 0, 0, 0, 0, 0, 0);
                check("exec.src", 32'({alu_src, ext_op}), 32'({ins.aluSrc, ins.extOp}));
            end
        endcase
        if (!needMem && !needWb) modelRetired++;
        nextCycle();
        if (needMem) begin
            for (int k = 0; k <= mDly; k++) begin
                mem_ready = (k == mDly);
                #1;
                check("mem.state", 32'(state), 4);
                strobes("mem", 0, 0, 1, ins.kind == K_STORE, 1, 0,
                        (ins.kind == K_STORE) && mem_ready, 0);
                check("mem.dm_sel", 32'(dm_sel), 32'(ins.dmSel));
                nextCycle();
            end
            if (ins.kind == K_STORE) modelRetired++;
        end
        if (needWb) begin
            mem_ready = 1'($urandom);
            #1;
            check("wb.state", 32'(state), 5);
            strobes("wb", 0, 0, 0, 0, 0, 1, 1, 0);
            check("wb.dst", 32'({reg_dst, mem2reg}), 32'({ins.regDst, ins.mem2reg}));
            modelRetired++;
            nextCycle();
        end
        check("retired", retired, 32'(modelRetired));
        check("bus_err", 32'(bus_err), 0);
    endtask

    task automatic timeoutRun(input bit inMem);
        if (inMem) begin
            op = 6'h23; funct = 6'h00; mem_ready = 1'b1;
            nextCycle();
            mem_ready = 1'b0;
            nextCycle();
            nextCycle();
        end
        mem_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            check("tmo.wait.state", 32'(state), inMem ? 4 : 1);
            check("tmo.wait.req", 32'(mem_req), 1);
            check("tmo.wait.bus_err", 32'(bus_err), 0);
            nextCycle();
        end
        for (int k = 0; k < 5; k++) begin
            mem_ready = 1'($urandom); op = 6'($urandom);
            #1;
            check("halt.state", 32'(state), 6);
            check("halt.bus_err", 32'(bus_err), 1);
            strobes("halt", 0, 0, 0, 0, 0, 0, 0, 0);
            nextCycle();
        end
        rst_n = 1'b0;
        #1;
        allZero("halt.reset");
    endtask

    initial begin
        tbl[0]  = mk(6'h00, 6'h21, K_ALU, 1, 0, 0, 0, 0);
        tbl[1]  = mk(6'h00, 6'h23, K_ALU, 1, 0, 0, 0, 0);
        tbl[2]  = mk(6'h00, 6'h06, K_ALU, 1, 0, 0, 0, 0);
        tbl[3]  = mk(6'h00, 6'h08, K_JR,  0, 0, 0, 0, 0);
        tbl[4]  = mk(6'h0D, 6'h00, K_ALU, 0, 0, 0, 1, 0);
        tbl[5]  = mk(6'h0E, 6'h00, K_ALU, 0, 0, 0, 1, 0);
        tbl[6]  = mk(6'h0F, 6'h00, K_ALU, 0, 0, 1, 1, 0);
        tbl[7]  = mk(6'h23, 6'h00, K_LOAD, 0, 1, 2, 1, 0);
        tbl[8]  = mk(6'h21, 6'h00, K_LOAD, 0, 1, 2, 1, 1);
        tbl[9]  = mk(6'h2B, 6'h00, K_STORE, 0, 0, 2, 1, 0);
        tbl[10] = mk(6'h04, 6'h00, K_BR,  0, 0, 3, 0, 0);
        tbl[11] = mk(6'h07, 6'h00, K_BR,  0, 0, 3, 0, 0);
        tbl[12] = mk(6'h02, 6'h00, K_J,   0, 0, 0, 0, 0);
        tbl[13] = mk(6'h03, 6'h00, K_JAL, 2, 2, 0, 0, 0);
        tbl[14] = mk(6'h3F, 6'h00, K_BAD, 0, 0, 0, 0, 0);
        tbl[15] = mk(6'h00, 6'h00, K_BAD, 0, 0, 0, 0, 0);
        tbl[16] = mk(6'h08, 6'h00, K_BAD, 0, 0, 0, 0, 0);

        doReset();
        runInstr(tbl[0], 0, 0, 0);
        runInstr(tbl[7], 3, 2, 0);
        runInstr(tbl[10], 0, 0, 0);
        runInstr(tbl[10], 0, 0, 1);
        runInstr(tbl[13], 1, 0, 0);
        runInstr(tbl[14], 0, 0, 0);
        runInstr(tbl[9], 15, 15, 0);
        runInstr(tbl[8], 0, 15, 0);

        for (int n = 0; n < 120; n++) begin
            instr_t ins;
            ins = tbl[$urandom_range(0, 16)];
            if (ins.op != 6'h00) ins.funct = 6'($urandom);
            runInstr(ins, $urandom_range(0, 5), $urandom_range(0, 5),
                     1'($urandom));
        end

        timeoutRun(1'b0);
        doReset();
        runInstr(tbl[5], 2, 0, 0);
        timeoutRun(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
